// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hazardState_e  : controller FSM states
//   TIMEOUT_CYCLES : MEM_WAIT cycles tolerated before a data-memory fault
//   REG_ADDR_WIDTH : register-file address width
package pipeline_hazard_controller_pkg;

    localparam int unsigned TIMEOUT_CYCLES = 255;
    localparam int unsigned REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StFault   = 2'd2
    } hazardState_e;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard bus between the pipeline datapath and the hazard controller.
//   Inputs to the controller : ID source registers/uses, EX load/dest/branch,
//                              MEM request, data-memory ready.
//   Outputs from controller  : per-register stall/flush, memFault, stallCycleCount.
// modport master : pipeline side (drives status, receives control)
// modport slave  : controller side
interface pipeline_hazard_controller_if;
    import pipeline_hazard_controller_pkg::*;

    logic [REG_ADDR_WIDTH-1:0] id_registerReadAddressA;
    logic [REG_ADDR_WIDTH-1:0] id_registerReadAddressB;
    logic                      id_usesA;
    logic                      id_usesB;
    logic                      ex_isLoad;
    logic [REG_ADDR_WIDTH-1:0] ex_registerWriteAddress;
    logic                      ex_branchTaken;
    logic                      mem_memoryRequest;
    logic                      dmem_ready;

    logic                      pcStall;
    logic                      ifIdStall;
    logic                      idExStall;
    logic                      exMemStall;
    logic                      ifIdFlush;
    logic                      idExFlush;
    logic                      memWbFlush;
    logic                      memFault;
    logic [31:0]               stallCycleCount;

    modport master (
        output id_registerReadAddressA, id_registerReadAddressB, id_usesA, id_usesB,
               ex_isLoad, ex_registerWriteAddress, ex_branchTaken,
               mem_memoryRequest, dmem_ready,
        input  pcStall, ifIdStall, idExStall, exMemStall,
               ifIdFlush, idExFlush, memWbFlush, memFault, stallCycleCount
    );

    modport slave (
        input  id_registerReadAddressA, id_registerReadAddressB, id_usesA, id_usesB,
               ex_isLoad, ex_registerWriteAddress, ex_branchTaken,
               mem_memoryRequest, dmem_ready,
        output pcStall, ifIdStall, idExStall, exMemStall,
               ifIdFlush, idExFlush, memWbFlush, memFault, stallCycleCount
    );

endinterface

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Combinational load-use hazard detector.
//   idReadAddrA_i/B_i : ID source registers
//   idUsesA_i/B_i     : ID instruction really reads that source
//   exIsLoad_i        : EX instruction is a load
//   exWriteAddr_i     : EX destination register
//   loadUse_o         : ID needs a value the EX load has not produced yet
module load_use_detector
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [REG_ADDR_WIDTH-1:0] idReadAddrA_i,
    input  logic [REG_ADDR_WIDTH-1:0] idReadAddrB_i,
    input  logic                      idUsesA_i,
    input  logic                      idUsesB_i,
    input  logic                      exIsLoad_i,
    input  logic [REG_ADDR_WIDTH-1:0] exWriteAddr_i,
    output logic                      loadUse_o
);

    logic hitA;
    logic hitB;

    assign hitA = idUsesA_i && (idReadAddrA_i == exWriteAddr_i);
    assign hitB = idUsesB_i && (idReadAddrB_i == exWriteAddr_i);

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign loadUse_o = exIsLoad_i && (exWriteAddr_i != '0) && (hitA || hitB);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use interlock, branch flush, data-memory
// wait with timeout fault, and a stalled-cycle counter.
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   hazard  : hazard bus (slave side), see pipeline_hazard_controller_if
// Priority of actions: FAULT > memory stall > taken branch > load-use > none.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
(
    input logic                         clock,
    input logic                         reset_n,
    pipeline_hazard_controller_if.slave hazard
);

    localparam logic [7:0] TimeoutCount = 8'(TIMEOUT_CYCLES);

    hazardState_e state_q, state_d;
    logic [7:0]   waitCounter_q, waitCounter_d;
    logic [31:0]  stallCycleCount_q;

    logic loadUse;
    logic memStall;
    logic pcStall, ifIdStall, idExStall, exMemStall;
    logic ifIdFlush, idExFlush, memWbFlush, memFault;

    load_use_detector u_loadUseDetector (
        .idReadAddrA_i (hazard.id_registerReadAddressA),
        .idReadAddrB_i (hazard.id_registerReadAddressB),
        .idUsesA_i     (hazard.id_usesA),
        .idUsesB_i     (hazard.id_usesB),
        .exIsLoad_i    (hazard.ex_isLoad),
        .exWriteAddr_i (hazard.ex_registerWriteAddress),
        .loadUse_o     (loadUse)
    );

    always_comb begin
        state_d       = state_q;
        waitCounter_d = waitCounter_q;
        memStall      = 1'b0;
        pcStall       = 1'b0;
        ifIdStall     = 1'b0;
        idExStall     = 1'b0;
        exMemStall    = 1'b0;
        ifIdFlush     = 1'b0;
        idExFlush     = 1'b0;
        memWbFlush    = 1'b0;
        memFault      = 1'b0;

        if (state_q != StFault) begin
            memStall = hazard.mem_memoryRequest && !hazard.dmem_ready;
        end

        unique case (state_q)
            StRun: begin
                if (memStall) begin
                    state_d       = StMemWait;
                    waitCounter_d = '0;
                end
            end
            StMemWait: begin
                // Completion is checked first so ready on the last allowed cycle wins.
                if (!memStall) begin
                    state_d = StRun;
                end else if (waitCounter_q == TimeoutCount) begin
                    state_d = StFault;
                end else begin
                    waitCounter_d = waitCounter_q + 8'd1;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (state_q == StFault) begin
            {pcStall, ifIdStall, idExStall, exMemStall} = 4'b1111;
            memWbFlush = 1'b1;
            memFault   = 1'b1;
        end else if (memStall) begin
            // Freeze the front of the pipe; branch/load-use wait until memory completes.
            {pcStall, ifIdStall, idExStall, exMemStall} = 4'b1111;
            memWbFlush = 1'b1;
        end else if (hazard.ex_branchTaken) begin
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
        end else if (loadUse) begin
            pcStall   = 1'b1;
            ifIdStall = 1'b1;
            idExFlush = 1'b1;
        end

        // Outputs are forced quiet for as long as reset is held, not just after an edge.
        if (!reset_n) begin
            {pcStall, ifIdStall, idExStall, exMemStall} = 4'b0000;
            {ifIdFlush, idExFlush, memWbFlush, memFault} = 4'b0000;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= StRun;
            waitCounter_q     <= '0;
            stallCycleCount_q <= '0;
        end else begin
            state_q       <= state_d;
            waitCounter_q <= waitCounter_d;
            if (pcStall) begin
                stallCycleCount_q <= stallCycleCount_q + 32'd1;
            end
        end
    end

    assign hazard.pcStall         = pcStall;
    assign hazard.ifIdStall       = ifIdStall;
    assign hazard.idExStall       = idExStall;
    assign hazard.exMemStall      = exMemStall;
    assign hazard.ifIdFlush       = ifIdFlush;
    assign hazard.idExFlush       = idExFlush;
    assign hazard.memWbFlush      = memWbFlush;
    assign hazard.memFault        = memFault;
    assign hazard.stallCycleCount = stallCycleCount_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller. The stimulus process sets
// inputs just after a rising edge and queues the expected outputs for that
// cycle; the monitor samples every falling edge and checks against the queue.
// Control vector bit order: {pcStall, ifIdStall, idExStall, exMemStall,
//                            ifIdFlush, idExFlush, memWbFlush, memFault}.
module tb_pipeline_hazard_controller;

    localparam logic [7:0] None = 8'h00;
    localparam logic [7:0] Lu   = 8'hC4;
    localparam logic [7:0] Br   = 8'h0C;
    localparam logic [7:0] Ms   = 8'hF2;
    localparam logic [7:0] Flt  = 8'hF3;

    typedef struct {
        string       tag;
        logic [7:0]  ctl;
        logic [31:0] cnt;
    } exp_t;

    logic clock;
    logic reset_n;
    exp_t sb[$];
    int   nChecks;
    int   nFails;
    bit   stimDone;

    pipeline_hazard_controller_if hif ();

    pipeline_hazard_controller dut (
        .clock   (clock),
        .reset_n (reset_n),
        .hazard  (hif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        hif.id_registerReadAddressA = '0;
        hif.id_registerReadAddressB = '0;
        hif.id_usesA                = 1'b0;
        hif.id_usesB                = 1'b0;
        hif.ex_isLoad               = 1'b0;
        hif.ex_registerWriteAddress = '0;
        hif.ex_branchTaken          = 1'b0;
        hif.mem_memoryRequest       = 1'b0;
        hif.dmem_ready              = 1'b0;
    endtask

    task automatic setLoadUseA(input logic [4:0] r);
        hif.ex_isLoad               = 1'b1;
        hif.ex_registerWriteAddress = r;
        hif.id_registerReadAddressA = r;
        hif.id_usesA                = 1'b1;
    endtask

    // Queue this cycle's expectation, then advance to just after the next edge.
    task automatic tick(input string tag, input logic [7:0] ctl, input logic [31:0] cnt);
        exp_t e;
        e.tag = tag;
        e.ctl = ctl;
        e.cnt = cnt;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Monitor: outputs are combinational, so every cycle presents a result.
    initial begin
        exp_t        e;
        logic [7:0]  got;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {hif.pcStall, hif.ifIdStall, hif.idExStall, hif.exMemStall,
                       hif.ifIdFlush, hif.idExFlush, hif.memWbFlush, hif.memFault};
                nChecks++;
                if (got !== e.ctl) begin
                    nFails++;
                    $display("FAIL %s ctl: got %b want %b", e.tag, got, e.ctl);
                end
                nChecks++;
                if (hif.stallCycleCount !== e.cnt) begin
                    nFails++;
                    $display("FAIL %s stallCycleCount: got %0d want %0d",
                             e.tag, hif.stallCycleCount, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nChecks  = 0;
        nFails   = 0;
        stimDone = 1'b0;
        reset_n  = 1'b0;
        idle();
        @(posedge clock);
        #1;

        // Reset: outputs quiet even with a load-use hazard on the inputs.
        tick("reset_idle", None, 0);
        setLoadUseA(5'd5);
        tick("reset_gated", None, 0);
        reset_n = 1'b1;
        idle();
        tick("idle", None, 0);

        // Load-use through A: one bubble, then clear.
        setLoadUseA(5'd5);
        tick("lu_a", Lu, 0);
        hif.ex_isLoad = 1'b0;
        tick("lu_a_after", None, 1);

        // Load-use through B, then same address with usesB low.
        idle();
        hif.ex_isLoad = 1'b1;
        hif.ex_registerWriteAddress = 5'd7;
        hif.id_registerReadAddressB = 5'd7;
        hif.id_usesB = 1'b1;
        tick("lu_b", Lu, 1);
        hif.id_usesB = 1'b0;
        tick("lu_b_unused", None, 2);

        // Load to $0 is harmless; load-use coinciding with a branch flushes only.
        idle();
        setLoadUseA(5'd0);
        tick("lu_r0", None, 2);
        setLoadUseA(5'd5);
        hif.ex_branchTaken = 1'b1;
        tick("lu_branch", Br, 2);
        idle();
        tick("idle2", None, 2);

        // Three-cycle memory wait.
        hif.mem_memoryRequest = 1'b1;
        tick("mw3_0", Ms, 2);
        tick("mw3_1", Ms, 3);
        tick("mw3_2", Ms, 4);
        hif.dmem_ready = 1'b1;
        tick("mw3_done", None, 5);
        idle();
        tick("mw3_idle", None, 5);

        // Branch held back by a memory stall, acted on once memory completes.
        hif.mem_memoryRequest = 1'b1;
        hif.ex_branchTaken = 1'b1;
        tick("ms_br_0", Ms, 5);
        tick("ms_br_1", Ms, 6);
        hif.dmem_ready = 1'b1;
        tick("ms_br_done", Br, 7);
        idle();
        tick("ms_br_idle", None, 7);

        // Load-use held back by a memory stall.
        hif.mem_memoryRequest = 1'b1;
        setLoadUseA(5'd9);
        tick("ms_lu_0", Ms, 7);
        hif.dmem_ready = 1'b1;
        tick("ms_lu_done", Lu, 8);
        idle();
        tick("ms_lu_idle", None, 9);

        // Ready arrives exactly when the wait counter reads 255: no fault.
        hif.mem_memoryRequest = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick("edge_wait", Ms, 32'(9 + i));
        end
        hif.dmem_ready = 1'b1;
        tick("edge_done", None, 265);
        idle();
        tick("edge_idle", None, 265);

        // One cycle longer: timeout fault, sticky and frozen.
        hif.mem_memoryRequest = 1'b1;
        for (int i = 0; i < 257; i++) begin
            tick("to_wait", Ms, 32'(265 + i));
        end
        tick("to_fault", Flt, 522);
        hif.dmem_ready = 1'b1;
        tick("fault_ready", Flt, 523);
        hif.ex_branchTaken = 1'b1;
        tick("fault_branch", Flt, 524);

        // Reset out of FAULT.
        reset_n = 1'b0;
        tick("fault_reset", None, 0);
        reset_n = 1'b1;
        idle();
        tick("post_fault", None, 0);
        setLoadUseA(5'd3);
        tick("post_fault_lu", Lu, 0);
        idle();
        tick("post_fault_idle", None, 1);

        // Reset in the middle of a memory wait.
        hif.mem_memoryRequest = 1'b1;
        tick("mw_rst_0", Ms, 1);
        tick("mw_rst_1", Ms, 2);
        reset_n = 1'b0;
        tick("mw_rst_assert", None, 0);
        reset_n = 1'b1;
        idle();
        tick("mw_rst_release", None, 0);
        tick("mw_rst_idle", None, 0);

        @(negedge clock);
        #1;
        nChecks++;
        if (sb.size() != 0) begin
            nFails++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        stimDone = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
